// File: rtl/state_dumper.sv
// Streams a 42-word CPU state snapshot (cycle, PC, x0..x31, dmem[0..7]) over a
// valid/ready port while holding the CPU frozen.
module state_dumper (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] cycle_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        dout_last_o,
  output logic        freeze_o,
  output logic        done_o,
  output logic [15:0] dump_count_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

  localparam logic [5:0] RegBase = 6'd2;
  localparam logic [5:0] MemBase = 6'd34;
  localparam logic [5:0] LastIdx = 6'd41;

  state_e      state_q;
  logic [5:0]  idx_q;
  logic [31:0] cycle_q;
  logic [31:0] pc_q;
  logic [31:0] dout_q;
  logic        valid_q;
  logic        last_q;
  logic        done_q;
  logic [15:0] count_q;
  logic [15:0] dump_count_q;

  logic [5:0]  reg_off;
  logic [5:0]  mem_off;
  logic [31:0] word_sel;

  assign reg_off = idx_q - RegBase;
  assign mem_off = idx_q - MemBase;

  // Addresses are live only during FETCH so the sources see a stable index.
  always_comb begin
    reg_addr_o = '0;
    mem_addr_o = '0;
    if (state_q == StFetch) begin
      if (idx_q >= MemBase) begin
        mem_addr_o = mem_off[4:0];
      end else if (idx_q >= RegBase) begin
        reg_addr_o = reg_off[4:0];
      end
    end
  end

  always_comb begin
    word_sel = mem_data_i;
    if (idx_q == 6'd0) begin
      word_sel = cycle_q;
    end else if (idx_q == 6'd1) begin
      word_sel = pc_q;
    end else if (idx_q < MemBase) begin
      word_sel = reg_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cycle_q      <= '0;
      pc_q         <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      dump_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            cycle_q <= cycle_i;
            pc_q    <= pc_i;
            idx_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          dout_q  <= word_sel;
          valid_q <= 1'b1;
          last_q  <= (idx_q == LastIdx);
          state_q <= StWait;
        end
        StWait: begin
          if (dout_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          done_q       <= 1'b0;
          dump_count_q <= dump_count_q + 16'd1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign count_q      = dump_count_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign dout_last_o  = last_q;
  assign done_o       = done_q;
  assign dump_count_o = count_q;
  assign freeze_o     = (state_q != StIdle);

endmodule

// File: tb/tb_state_dumper.sv
// Bench for state_dumper: word-level model of the dump stream checked every
// cycle, plus directed scenarios with literal expectations.
module tb_state_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_main = 1'b1, rst_inj = 1'b0, start_main = 1'b0, start_inj = 1'b0;
  logic        rst_i, start_i;
  logic        ready = 1'b1;
  logic [31:0] cycle_in = '0, pc_in = '0;
  logic [31:0] regs [32];
  logic [31:0] mem  [8];
  logic [4:0]  reg_addr, mem_addr;
  logic [31:0] reg_data, mem_data, dout;
  logic        valid, last, freeze, done;
  logic [15:0] dcount;

  assign rst_i    = rst_main | rst_inj;
  assign start_i  = start_main | start_inj;
  assign reg_data = regs[reg_addr];
  assign mem_data = mem[mem_addr];

  state_dumper dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .cycle_i      (cycle_in),
    .pc_i         (pc_in),
    .reg_addr_o   (reg_addr),
    .reg_data_i   (reg_data),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .dout_o       (dout),
    .dout_valid_o (valid),
    .dout_ready_i (ready),
    .dout_last_o  (last),
    .freeze_o     (freeze),
    .done_o       (done),
    .dump_count_o (dcount)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: which word is outstanding and whether it has been fetched yet.
  bit          armed = 0, rst_prev = 0, active = 0, fetched = 0, prev_hold = 0;
  int          word_n = 0, ndone = 0, words_rx = 0, busy = 0, stall_seen = 0, aborts = 0;
  logic [31:0] expw [42];
  logic [31:0] got  [42];
  logic [31:0] prev_dout;
  logic        prev_last;
  logic [15:0] count_offset = '0;

  always @(negedge clk) begin
    logic [15:0] exp_cnt;
    int          ea_reg, ea_mem;
    if (rst_i) begin
      armed = 1;
      if (active) aborts++;
      active    = 0;
      fetched   = 0;
      word_n    = 0;
      ndone     = 0;
      prev_hold = 0;
      rst_prev  = 1;
    end else if (armed) begin
      if (rst_prev) begin
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        check("rst_count", dcount, 0);
        check("rst_freeze", freeze, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
      end
      rst_prev = 0;
      if (prev_hold) begin
        check("hold_valid", valid, 1);
        check("hold_dout", dout, prev_dout);
        check("hold_last", last, prev_last);
      end
      exp_cnt = count_offset + 16'(ndone);
      check("dump_count", dcount, exp_cnt);
      check("freeze", freeze, active);
      check("done", done, active && word_n == 42);
      if (active) busy++;
      if (!active || word_n == 42) begin
        check("valid_idle", valid, 0);
        check("last_idle", last, 0);
      end else if (!fetched) begin
        ea_reg = (word_n >= 2 && word_n <= 33) ? word_n - 2 : 0;
        ea_mem = (word_n >= 34) ? word_n - 34 : 0;
        check("fetch_valid", valid, 0);
        check("fetch_last", last, 0);
        check("reg_addr", reg_addr, ea_reg);
        check("mem_addr", mem_addr, ea_mem);
        fetched = 1;
      end else begin
        check("wait_valid", valid, 1);
        check("word", dout, expw[word_n]);
        check("last", last, word_n == 41);
        if (ready) begin
          got[word_n] = dout;
          word_n++;
          words_rx++;
          fetched = 0;
        end else begin
          stall_seen++;
        end
      end
      if (active && word_n == 42 && done) begin
        ndone++;
        active = 0;
      end else if (!active && start_i) begin
        expw[0] = cycle_in;
        expw[1] = pc_in;
        for (int i = 0; i < 32; i++) expw[2 + i] = regs[i];
        for (int j = 0; j < 8; j++) expw[34 + j] = mem[j];
        active     = 1;
        fetched    = 0;
        word_n     = 0;
        words_rx   = 0;
        busy       = 0;
        stall_seen = 0;
      end
    end
    prev_hold = armed && !rst_i && valid && !ready;
    prev_dout = dout;
    prev_last = last;
  end

  // Sink and disturbance driver, keyed to the model's word index.
  int stall_idx = -1, stall_len = 0, inj_start_idx = -1, inj_rst_idx = -1, stall_cnt = 0;
  bit start_fired = 0, rst_fired = 0;

  always @(posedge clk) begin
    #1;
    if (valid && word_n == stall_idx && stall_cnt < stall_len) begin
      ready = 1'b0;
      stall_cnt++;
    end else begin
      ready = 1'b1;
    end
    if (start_inj) start_inj = 1'b0;
    else if (!start_fired && valid && word_n == inj_start_idx) begin
      start_inj   = 1'b1;
      start_fired = 1;
    end
    if (rst_inj) rst_inj = 1'b0;
    else if (!rst_fired && valid && word_n == inj_rst_idx) begin
      rst_inj   = 1'b1;
      rst_fired = 1;
    end
  end

  task automatic start_dump();
    start_main = 1'b1;
    @(posedge clk);
    #1;
    start_main = 1'b0;
  endtask

  // Returns at posedge+1 of the IDLE cycle following DONE.
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check("wait_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, n;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int j = 0; j < 8; j++) mem[j] = '0;
    regs[5]  = 32'd3;
    regs[31] = 32'h1234_5678;
    mem[0]   = 32'd5;
    mem[3]   = 32'h0000_0C0C;
    mem[7]   = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    rst_main = 1'b0;

    // Basic dump
    cycle_in = 32'd7;
    pc_in    = 32'h1C;
    start_dump();
    wait_done();
    check("t1_words", words_rx, 42);
    check("t1_cycles", busy, 85);
    check("t1_w0", got[0], 32'd7);
    check("t1_w1", got[1], 32'd28);
    check("t1_w4", got[4], 32'd0);
    check("t1_w7", got[7], 32'd3);
    check("t1_w33", got[33], 32'h1234_5678);
    check("t1_w34", got[34], 32'd5);
    check("t1_w41", got[41], 32'hDEAD_BEEF);
    check("t1_count", dcount, 1);

    // Backpressure on index 2 (x0)
    stall_idx = 2;
    stall_len = 10;
    cycle_in  = 32'd100;
    pc_in     = 32'h40;
    start_dump();
    wait_done();
    check("t2_stall", stall_seen, 10);
    check("t2_words", words_rx, 42);
    check("t2_cycles", busy, 95);
    check("t2_w2", got[2], 32'd0);
    check("t2_count", dcount, 2);

    // Start pulse while busy
    inj_start_idx = 20;
    start_dump();
    wait_done();
    check("t3_words", words_rx, 42);
    check("t3_cycles", busy, 85);
    check("t3_count", dcount, 3);

    // Reset mid-dump, then restart
    inj_rst_idx = 15;
    start_dump();
    a0 = aborts;
    n  = 0;
    while (aborts == a0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t4_abort", aborts - a0, 1);
    @(negedge clk);
    check("t4_freeze", freeze, 0);
    check("t4_valid", valid, 0);
    check("t4_done", done, 0);
    check("t4_count", dcount, 0);
    @(posedge clk);
    #1;
    cycle_in = 32'd55;
    start_dump();
    @(negedge clk);
    check("t4_restart_freeze", freeze, 1);
    wait_done();
    check("t4_w0", got[0], 32'd55);
    check("t4_words", words_rx, 42);
    check("t4_count2", dcount, 1);

    // Start in the IDLE cycle straight after DONE
    cycle_in = 32'd9;
    start_dump();
    @(negedge clk);
    check("t5_freeze", freeze, 1);
    wait_done();
    check("t5_w0", got[0], 32'd9);
    check("t5_count", dcount, 2);

    // Counter wrap from 0xFFFF
    force dut.dump_count_q = 16'hFFFF;
    count_offset = 16'hFFFF - 16'(ndone);
    @(posedge clk);
    #1;
    release dut.dump_count_q;
    start_dump();
    wait_done();
    check("t6_wrap", dcount, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
